// File: rtl/hartslag_meter.sv
// Heart-beat front-end: sync + debounce, beat detect, ms-tick interval measurement with artefact and timeout handling.
// Latency: beat DEBOUNCE_CYCLES+3 cycles after a clean pin edge, interval/flags one cycle after beat; no backpressure.
// HARTSLAG_AVG_EN: interval and hr_high follow the mean of the last 4 accepted intervals.
module hartslag_meter #(
  parameter int TICK_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 64,
  parameter int MIN_INTERVAL    = 300,
  parameter int MAX_INTERVAL    = 2000,
  parameter int HIGH_INTERVAL   = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hartslagIngang,
  output logic        beat,
  output logic [11:0] interval,
  output logic        interval_valid,
  output logic        hr_high,
  output logic        hr_lost
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [11:0]   MIN_I     = 12'(MIN_INTERVAL);
  localparam logic [11:0]   MAX_I     = 12'(MAX_INTERVAL);
  localparam logic [11:0]   HIGH_I    = 12'(HIGH_INTERVAL);

  typedef enum logic [1:0] {IDLE, MEASURE, LOST} state_t;

  logic          sync1, sync2, lvl, lvl_q;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  logic          tick;
  logic [11:0]   icnt;
  state_t        state;

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      dcnt  <= '0;
      beat  <= 1'b0;
      tcnt  <= '0;
    end else begin
      sync1 <= hartslagIngang;
      sync2 <= sync1;
      lvl_q <= lvl;
      beat  <= lvl & ~lvl_q;
      tcnt  <= tick ? '0 : tcnt + 1'b1;
      // Any cycle where the synced input agrees with the level restarts the stability count
      if (sync2 != lvl) begin
        if (dcnt == DEB_LAST) begin
          lvl  <= sync2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

`ifdef HARTSLAG_AVG_EN
  logic [11:0] hist [4];
  logic [2:0]  hcnt;
  logic [13:0] avg_sum;
  logic [11:0] avg;

  // Sum of the incoming interval and the three youngest stored ones
  assign avg_sum = {2'b00, icnt} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
  assign avg     = avg_sum[13:2];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      icnt           <= '0;
      interval       <= '0;
      interval_valid <= 1'b0;
      hr_high        <= 1'b0;
      hr_lost        <= 1'b1;
`ifdef HARTSLAG_AVG_EN
      hcnt           <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
`endif
    end else begin
      interval_valid <= 1'b0;
      case (state)
        IDLE, LOST: begin
          if (beat) begin
            state <= MEASURE;
            icnt  <= '0;
          end
        end
        MEASURE: begin
          // Timeout takes priority; a coincident beat simply restarts the measurement
          if (icnt >= MAX_I) begin
            hr_lost <= 1'b1;
            hr_high <= 1'b0;
            icnt    <= '0;
            state   <= beat ? MEASURE : LOST;
`ifdef HARTSLAG_AVG_EN
            hcnt    <= '0;
            for (int i = 0; i < 4; i++) hist[i] <= '0;
`endif
          end else if (beat && icnt >= MIN_I) begin
            icnt    <= '0;
            hr_lost <= 1'b0;
`ifdef HARTSLAG_AVG_EN
            hist[0] <= icnt;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            if (hcnt != 3'd4) hcnt <= hcnt + 1'b1;
            if (hcnt >= 3'd3) begin
              interval       <= avg;
              interval_valid <= 1'b1;
              hr_high        <= (avg <= HIGH_I);
            end
`else
            interval       <= icnt;
            interval_valid <= 1'b1;
            hr_high        <= (icnt <= HIGH_I);
`endif
          end else if (tick) begin
            icnt <= icnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hartslag_meter.sv
// Directed bench for hartslag_meter: expected interval reports are queued by the stimulus and popped by a monitor.
module tb_hartslag_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hin;
  logic        beat;
  logic [11:0] interval;
  logic        interval_valid;
  logic        hr_high;
  logic        hr_lost;

  typedef struct {
    int ival;
    bit high;
  } exp_t;

  exp_t expq[$];
  int   checks    = 0;
  int   errors    = 0;
  int   nbeat     = 0;
  int   exp_beats = 0;

  always #5 clk = ~clk;

  hartslag_meter #(
    .TICK_DIV(10), .DEBOUNCE_CYCLES(4), .MIN_INTERVAL(30),
    .MAX_INTERVAL(200), .HIGH_INTERVAL(50)
  ) dut (
    .clk(clk), .reset(reset), .hartslagIngang(hin), .beat(beat),
    .interval(interval), .interval_valid(interval_valid),
    .hr_high(hr_high), .hr_lost(hr_lost)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push(input int ival, input bit high);
    exp_t e;
    e.ival = ival;
    e.high = high;
    expq.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean pulse; p is the cycle count until the next pulse starts
  task automatic pulse(input int p);
    hin = 1'b1; exp_beats++; cyc(20);
    hin = 1'b0; cyc(p - 20);
  endtask

  task automatic glitch(input int w);
    hin = 1'b1; cyc(w);
    hin = 1'b0; cyc(50 - w);
  endtask

  // Bounces before the stable rising edge (not counted in p) and on the falling edge
  task automatic bounce_pulse(input int p);
    hin = 1'b1; cyc(2); hin = 1'b0; cyc(2);
    hin = 1'b1; cyc(1); hin = 1'b0; cyc(2);
    hin = 1'b1; exp_beats++; cyc(20);
    hin = 1'b0; cyc(1); hin = 1'b1; cyc(1);
    hin = 1'b0; cyc(p - 22);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_beat"}, beat, 0);
    chk({tag, "_interval"}, interval, 0);
    chk({tag, "_valid"}, interval_valid, 0);
    chk({tag, "_hr_high"}, hr_high, 0);
    chk({tag, "_hr_lost"}, hr_lost, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset === 1'b1) begin
      if (beat) nbeat++;
      if (interval_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid interval %0d expected no update", interval);
        end else begin
          e = expq.pop_front();
          chk_rng("sb_interval", int'(interval), e.ival - 1, e.ival + 1);
          chk("sb_hr_high", hr_high, e.high);
          chk("sb_hr_lost", hr_lost, 0);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    hin   = 1'b0;
    cyc(3);
    chk_reset_vals("reset");
    reset = 1'b1;
    cyc(300);
    chk("idle_hr_lost", hr_lost, 1);
    chk("idle_beats", nbeat, 0);

    pulse(800);                          // R1: first beat only
    chk("first_beats", nbeat, 1);
    chk("first_interval", interval, 0);
    chk("first_hr_lost", hr_lost, 1);
    push(80, 0); pulse(800);             // R2
    chk("r2_hr_lost", hr_lost, 0);
    push(80, 0); pulse(400);             // R3
    push(40, 1); pulse(400);             // R4
    chk("fast_hr_high", hr_high, 1);
    push(40, 1); pulse(800);             // R5
    push(80, 0); pulse(100);             // R6
    chk("slow_hr_high", hr_high, 0);
    pulse(700);                          // R7: artefact
    chk("artefact_beats", nbeat, 7);
    chk_rng("artefact_interval", int'(interval), 79, 81);
    push(80, 0); pulse(200);             // R8
    glitch(1); glitch(2); glitch(3);
    cyc(443);
    chk("glitch_beats", nbeat, 8);
    push(80, 0); bounce_pulse(400);      // R9
    chk("bounce_beats", nbeat, 9);

    push(40, 1);                         // R10 then silence
    hin = 1'b1; exp_beats++; cyc(20); hin = 1'b0; cyc(1930);
    chk("pre_timeout_hr_lost", hr_lost, 0);
    chk("pre_timeout_hr_high", hr_high, 1);
    cyc(150);
    chk("timeout_hr_lost", hr_lost, 1);
    chk("timeout_hr_high", hr_high, 0);
    chk_rng("timeout_interval_hold", int'(interval), 39, 41);
    pulse(400);                          // R11: restart after loss
    chk("restart_hr_lost", hr_lost, 1);
    push(40, 1);                         // R12 then reset mid-interval
    hin = 1'b1; exp_beats++; cyc(20); hin = 1'b0; cyc(180);
    chk("pre_reset_hr_high", hr_high, 1);
    chk("pre_reset_hr_lost", hr_lost, 0);
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    cyc(5);
    reset = 1'b1;
    pulse(800);                          // R13: first beat after reset
    chk("post_reset_hr_lost", hr_lost, 1);
    push(80, 0); pulse(100);             // R14
    cyc(20);
    chk("queue_drained", expq.size(), 0);
    chk("total_beats", nbeat, exp_beats);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hartslag_meter.md
Name: hartslag_meter

Overview:
- Front-end for the heart-rate input (hartslagIngang); directly upstream of the stress classifier.
- Synchronises and debounces the raw pulse line, then detects beats.
- Measures beat-to-beat interval in millisecond ticks and rejects artefacts.
- Outputs a validated interval, a high-heart-rate flag and a signal-lost flag, all in the clk domain.

Parameters:
TICK_DIV, 50000, clk cycles per ms tick (50 MHz clk)
DEBOUNCE_CYCLES, 64, consecutive stable cycles before the debounced level changes
MIN_INTERVAL, 300, shortest accepted interval in ticks (200 bpm); shorter beats are artefacts
MAX_INTERVAL, 2000, longest interval in ticks (30 bpm); reaching it declares signal lost
HIGH_INTERVAL, 500, accepted interval <= this counts as high rate (>=120 bpm)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
hartslagIngang  in  1  raw asynchronous pulse from heart sensor, high during beat
beat  out  1  one-cycle pulse per debounced rising edge, accepted or not
interval  out  12  last accepted interval in ms ticks
interval_valid  out  1  one-cycle pulse when interval updates
hr_high  out  1  high heart rate flag
hr_lost  out  1  no valid heartbeat present

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: beat=0, interval=0, interval_valid=0, hr_high=0, hr_lost=1.
  - Internals: all counters 0, synchroniser and debounced level 0, state IDLE.
- Input path:
  - 2-flop synchroniser.
  - Debounce counter increments while the synced value differs from the debounced level; resets to 0 when they match.
  - Debounced level takes the synced value when the count reaches DEBOUNCE_CYCLES-1.
  - beat asserts on the cycle after the debounced level rises 0->1.
  - Pin-to-beat latency is DEBOUNCE_CYCLES+3 cycles for a clean edge.
- Tick generator:
  - Free-running mod-TICK_DIV counter from reset; tick pulses when the count wraps to 0.
- Interval counter icnt (12 bit):
  - +1 on tick in MEASURE; saturates at MAX_INTERVAL.
  - Clears to 0 on every accepted beat and on entering MEASURE.
- State machine:
  - IDLE: wait for first beat. On beat -> MEASURE, icnt=0, no interval_valid. hr_lost remains 1.
  - MEASURE, beat with icnt < MIN_INTERVAL: artefact. Ignored; icnt keeps counting; no outputs change.
  - MEASURE, beat with MIN_INTERVAL <= icnt < MAX_INTERVAL: accepted.
    - Next cycle: interval=icnt, interval_valid=1 for one cycle.
    - hr_high=(icnt <= HIGH_INTERVAL), hr_lost=0, icnt=0.
  - MEASURE, icnt reaches MAX_INTERVAL: -> LOST. hr_lost=1, hr_high=0; interval holds its last value.
  - LOST: behaves as IDLE; next beat -> MEASURE with icnt=0, no interval_valid.
- Simultaneous events:
  - Beat on the same cycle icnt saturates: timeout wins; the beat restarts measurement as in LOST.
  - Tick and accepted beat on the same cycle: icnt clears to 0; the tick is not counted.
- Reset mid-measurement: everything returns to the reset values; the next beat is treated as a first beat.
- hartslagIngang held high: exactly one beat. Timeout still occurs after MAX_INTERVAL ticks.

Optional Feature:
- Macro: HARTSLAG_AVG_EN.
- Defined:
  - interval outputs the mean of the last 4 accepted intervals: 4-entry shift register, 14-bit sum, shift right by 2.
  - hr_high is evaluated on that mean.
  - After IDLE/LOST, the register refills. interval_valid is suppressed until 4 accepted intervals exist.
  - The shift register clears on entering LOST and on reset.
- Not defined: interval and hr_high use the single latest accepted interval, as specified above.

Test Plan:
- Sim parameters: TICK_DIV=10, DEBOUNCE_CYCLES=4, MIN_INTERVAL=30, MAX_INTERVAL=200, HIGH_INTERVAL=50.
- Reset then idle input -> hr_lost=1, hr_high=0, interval=0, interval_valid never pulses.
- Clean pulses every 800 cycles (80 ticks) -> first pulse: beat only. Later pulses: interval=80 (+/-1), interval_valid one cycle, hr_lost=0, hr_high=0.
- Pulses every 400 cycles (40 ticks) -> interval=40, hr_high=1. Switch to 80 ticks -> hr_high=0 after the first accepted beat.
- Pulse 100 cycles (10 ticks) after a valid beat -> beat pulses, no interval_valid, interval unchanged. The following beat at 80 ticks from the previous accepted beat reports interval=80.
- Glitches of 1-3 cycles width, plus bouncing edges -> no beat from glitches. Exactly one beat per bounced edge.
- No pulse for 2000 cycles after a valid beat -> hr_lost=1, hr_high=0 at icnt=200. Next pulse produces no interval_valid. Assert reset mid-interval -> all outputs return to their reset values immediately.
